// File: rtl/led_pkg.sv
// Shared definitions for the memory-mapped LED controller: channel modes,
// register byte offsets inside the 256-byte window and CH_CFG field positions.
package led_pkg;

    typedef enum logic [1:0] {
        LED_DIRECT    = 2'b00,
        LED_PWM       = 2'b01,
        LED_BLINK     = 2'b10,
        LED_PWM_BLINK = 2'b11
    } led_mode_t;

    localparam logic [7:0] OFS_DIRECT   = 8'h00;
    localparam logic [7:0] OFS_PRESCALE = 8'h04;
    localparam logic [7:0] OFS_BLINK    = 8'h08;
    localparam logic [7:0] OFS_STATUS   = 8'h0C;
    localparam logic [7:0] OFS_CH_BASE  = 8'h40;

    localparam int CFG_DUTY_LSB = 0;
    localparam int CFG_MODE_LSB = 16;
    localparam int CFG_MODE_MSB = 17;

endpackage

// File: rtl/led_timebase.sv
// Shared LED timebase: prescaler tick, PWM counter (only with LED_PWM_EN), blink step counter and phase.
// Outputs are registered; sync_clr_i restarts every counter and the phase on the next edge.
module led_timebase #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [15:0]         prescale_i,
    input  logic [23:0]         blink_i,
    input  logic                sync_clr_i,
    output logic [PWM_BITS-1:0] pwm_cnt_o,
    output logic                phase_o
);

    logic [15:0] presc_q, presc_d;
    logic [23:0] blink_cnt_q, blink_cnt_d;
    logic        phase_q, phase_d;
    logic        tick;
    logic        step;

    assign tick = (presc_q == prescale_i);

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_q, pwm_d;

    // The blink step is the PWM counter wrapping from all-ones back to zero.
    assign step = tick && (pwm_q == '1);

    always_comb begin
        pwm_d = pwm_q;
        if (sync_clr_i) begin
            pwm_d = '0;
        end else if (tick) begin
            pwm_d = pwm_q + PWM_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign pwm_cnt_o = pwm_q;
`else
    assign step      = tick;
    assign pwm_cnt_o = '0;
`endif

    always_comb begin
        presc_d     = presc_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (sync_clr_i) begin
            presc_d     = '0;
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else begin
            presc_d = tick ? 16'd0 : presc_q + 16'd1;
            if (step) begin
                if (blink_cnt_q == blink_i) begin
                    blink_cnt_d = '0;
                    phase_d     = ~phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 24'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/led_pwm_mm.sv
// Memory-mapped LED controller (direct/PWM/blink per channel); PWM dimming only with LED_PWM_EN defined.
// Bus has no wait states (combinational ack/data); LEDR is registered, one clk after the write edge.
module led_pwm_mm
    import led_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          NUM_LEDS  = 10,
    parameter int          PWM_BITS  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [NUM_LEDS-1:0] LEDR,
    input  logic                write_i,
    input  logic                read_i,
    input  logic [31:0]         addr_i,
    input  logic [31:0]         data_i,
    inout  wire  [31:0]         data_o,
    inout  wire                 ack_o
);

    logic                sel;
    logic                wr;
    logic [7:0]          ofs_w;
    logic [5:0]          ch_idx;
    logic                ch_area;
    logic                sync_clr;
    logic [31:0]         rdata;

    logic [NUM_LEDS-1:0] direct_q, direct_d;
    logic [15:0]         prescale_q, prescale_d;
    logic [23:0]         blink_q, blink_d;
    led_mode_t           mode_q [NUM_LEDS];
    led_mode_t           mode_d [NUM_LEDS];
    logic [NUM_LEDS-1:0] led_q, led_d;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic                phase;

    assign sel      = (addr_i[31:8] == BASE_ADDR[31:8]) && (read_i || write_i);
    assign wr       = sel && write_i;
    assign ofs_w    = {addr_i[7:2], 2'b00};
    assign ch_area  = (ofs_w >= OFS_CH_BASE);
    assign ch_idx   = addr_i[7:2] - 6'(OFS_CH_BASE >> 2);
    assign sync_clr = wr && ((ofs_w == OFS_PRESCALE) || (ofs_w == OFS_BLINK));

    led_timebase #(
        .PWM_BITS   (PWM_BITS)
    ) u_timebase (
        .clk        (clk),
        .rst_n      (rst_n),
        .prescale_i (prescale_q),
        .blink_i    (blink_q),
        .sync_clr_i (sync_clr),
        .pwm_cnt_o  (pwm_cnt),
        .phase_o    (phase)
    );

    always_comb begin
        direct_d   = direct_q;
        prescale_d = prescale_q;
        blink_d    = blink_q;
        mode_d     = mode_q;
        if (wr) begin
            case (ofs_w)
                OFS_DIRECT:   direct_d   = data_i[NUM_LEDS-1:0];
                OFS_PRESCALE: prescale_d = data_i[15:0];
                OFS_BLINK:    blink_d    = data_i[23:0];
                default: begin
                    for (int i = 0; i < NUM_LEDS; i++) begin
                        if (ch_area && (ch_idx == 6'(i))) begin
                            mode_d[i] = led_mode_t'(data_i[CFG_MODE_MSB:CFG_MODE_LSB]);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            direct_q   <= '0;
            prescale_q <= '0;
            blink_q    <= '0;
            led_q      <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                mode_q[i] <= LED_DIRECT;
            end
        end else begin
            direct_q   <= direct_d;
            prescale_q <= prescale_d;
            blink_q    <= blink_d;
            led_q      <= led_d;
            mode_q     <= mode_d;
        end
    end

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] duty_q [NUM_LEDS];
    logic [PWM_BITS-1:0] duty_d [NUM_LEDS];

    always_comb begin
        duty_d = duty_q;
        if (wr && ch_area) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (ch_idx == 6'(i)) begin
                    duty_d[i] = data_i[CFG_DUTY_LSB +: PWM_BITS];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                duty_q[i] <= '0;
            end
        end else begin
            duty_q <= duty_d;
        end
    end
`endif

    // Out-of-range channel slots and unused word offsets fall through to zero.
    always_comb begin
        rdata = '0;
        case (ofs_w)
            OFS_DIRECT:   rdata[NUM_LEDS-1:0] = direct_q;
            OFS_PRESCALE: rdata[15:0]         = prescale_q;
            OFS_BLINK:    rdata[23:0]         = blink_q;
            OFS_STATUS: begin
                rdata[NUM_LEDS-1:0] = led_q;
                rdata[31]           = phase;
            end
            default: begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    if (ch_area && (ch_idx == 6'(i))) begin
                        rdata[CFG_MODE_MSB:CFG_MODE_LSB] = mode_q[i];
`ifdef LED_PWM_EN
                        rdata[CFG_DUTY_LSB +: PWM_BITS]  = duty_q[i];
`endif
                    end
                end
            end
        endcase
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        logic pwm_hit;
        logic ch_led;

`ifdef LED_PWM_EN
        assign pwm_hit = (pwm_cnt < duty_q[i]);
`else
        // Without the PWM counter a PWM channel is simply fully on.
        assign pwm_hit = 1'b1;
`endif

        always_comb begin
            case (mode_q[i])
                LED_DIRECT: ch_led = direct_q[i];
                LED_PWM:    ch_led = pwm_hit;
                LED_BLINK:  ch_led = phase;
                default:    ch_led = pwm_hit && phase;
            endcase
        end

        assign led_d[i] = ch_led;
    end

    assign LEDR   = led_q;
    assign ack_o  = sel ? 1'b1 : 1'bz;
    assign data_o = sel ? rdata : 32'hzzzz_zzzz;

    logic unused_bits;
`ifdef LED_PWM_EN
    assign unused_bits = ^{addr_i[1:0], data_i};
`else
    assign unused_bits = ^{addr_i[1:0], data_i, pwm_cnt, CFG_DUTY_LSB[0]};
`endif

endmodule

// File: tb/tb_led_pwm_mm.sv
// Directed bench for led_pwm_mm: register table, window decode, PWM duty counts, blink timing, sync clear, async reset.
module tb_led_pwm_mm;

    localparam logic [31:0] BASE = 32'h4000_0000;
`ifdef LED_PWM_EN
    localparam bit PWM_ON = 1'b1;
`else
    localparam bit PWM_ON = 1'b0;
`endif
    // Blink half-period in clks for PRESCALE=3, BLINK=1.
    localparam int H = PWM_ON ? 2 * 256 * 4 : 2 * 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write_i = 1'b0;
    logic        read_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    wire  [31:0] data_w;
    wire         ack_w;
    logic [9:0]  ledr;

    int n_vec = 0;
    int n_bad = 0;

    led_pwm_mm #(
        .BASE_ADDR (BASE),
        .NUM_LEDS  (10),
        .PWM_BITS  (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .LEDR    (ledr),
        .write_i (write_i),
        .read_i  (read_i),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .data_o  (data_w),
        .ack_o   (ack_w)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        bit          wr;
        logic [7:0]  ofs;
        logic [31:0] wd;
        logic [31:0] dmask;
        logic [31:0] dexp;
        logic [9:0]  lexp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input bit wr, input logic [7:0] ofs, input logic [31:0] wd,
                       input logic [31:0] dmask, input logic [31:0] dexp, input logic [9:0] lexp);
        vec_t v;
        v.nm = nm; v.wr = wr; v.ofs = ofs; v.wd = wd;
        v.dmask = dmask; v.dexp = dexp; v.lexp = lexp;
        vecs.push_back(v);
    endtask

    task automatic do_write(input logic [7:0] ofs, input logic [31:0] wd);
        @(negedge clk);
        write_i = 1'b1;
        read_i  = 1'b0;
        addr_i  = BASE | {24'h0, ofs};
        data_i  = wd;
        @(posedge clk);
        #1;
        write_i = 1'b0;
    endtask

    task automatic count_on(output int n);
        n = 0;
        repeat (256) begin
            @(negedge clk);
            if (ledr[0] === 1'b1) n++;
        end
    endtask

    // Entered just after the edge that cleared the timebase (j = 0).
    task automatic blink_mon(input string tag);
        read_i = 1'b1;
        addr_i = BASE | 32'h0C;
        @(negedge clk);
        chk({tag, "_phase_j0"}, 32'(data_w[31]), 32'd0);
        for (int j = 1; j <= 2 * H + 1; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (j == H - 1 || j == H || j == H + 1 || j == 2 * H || j == 2 * H + 1) begin
                chk({tag, "_phase"}, 32'(data_w[31]), 32'((j / H) % 2));
                chk({tag, "_led1"}, 32'(ledr[1]), 32'(((j - 1) / H) % 2));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        add("rst_status",  1'b0, 8'h0C, 32'h0,         PWM_ON ? 32'hFFFF_FFFF : 32'h3FF, 32'h0, 10'h000);
        add("wr_direct",   1'b1, 8'h00, 32'h0000_02A5, 32'h3FF,       32'h0,         10'h000);
        add("rd_direct",   1'b0, 8'h00, 32'h0,         32'hFFFF_FFFF, 32'h0000_02A5, 10'h000);
        add("rd_ch1",      1'b0, 8'h44, 32'h0,         32'hFFFF_FFFF, 32'h0,         10'h2A5);
        add("rd_status",   1'b0, 8'h0C, 32'h0,         32'h3FF,       32'h0000_02A5, 10'h2A5);
        add("wr_unmapped", 1'b1, 8'h3C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         10'h2A5);
        add("rd_unmapped", 1'b0, 8'h3C, 32'h0,         32'hFFFF_FFFF, 32'h0,         10'h2A5);
        add("rd_direct2",  1'b0, 8'h00, 32'h0,         32'hFFFF_FFFF, 32'h0000_02A5, 10'h2A5);
        add("wr_ch10",     1'b1, 8'h68, 32'h0003_FFFF, 32'hFFFF_FFFF, 32'h0,         10'h2A5);
        add("rd_ch10",     1'b0, 8'h68, 32'h0,         32'hFFFF_FFFF, 32'h0,         10'h2A5);
        add("rd_ch0",      1'b0, 8'h40, 32'h0,         32'hFFFF_FFFF, 32'h0,         10'h2A5);
        add("wr_presc",    1'b1, 8'h04, 32'hFFFF_1234, 32'h0,         32'h0,         10'h2A5);
        add("rd_presc",    1'b0, 8'h04, 32'h0,         32'hFFFF_FFFF, 32'h0000_1234, 10'h2A5);
        add("wr_blink",    1'b1, 8'h08, 32'hFFAB_CDEF, 32'h0,         32'h0,         10'h2A5);
        add("rd_blink",    1'b0, 8'h08, 32'h0,         32'hFFFF_FFFF, 32'h00AB_CDEF, 10'h2A5);
        add("wr_ch3_m11",  1'b1, 8'h4C, 32'hFFFF_0080, 32'hFFFF_FFFF, 32'h0,         10'h2A5);
        add("rd_ch3_m11",  1'b0, 8'h4C, 32'h0,         32'hFFFF_FFFF, PWM_ON ? 32'h0003_0080 : 32'h0003_0000, 10'h2A5);
        add("wr_ch3_m01",  1'b1, 8'h4C, 32'h0001_0080, 32'h0,         32'h0,         10'h2A5);
        add("rd_ch3_m01",  1'b0, 8'h4C, 32'h0,         32'hFFFF_FFFF, PWM_ON ? 32'h0001_0080 : 32'h0001_0000, 10'h2A5);
        add("led_ch3_on",  1'b0, 8'h00, 32'h0,         32'hFFFF_FFFF, 32'h0000_02A5, 10'h2AD);
        add("wr_dir_ones", 1'b1, 8'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_02A5, 10'h2AD);
        add("rd_dir_ones", 1'b0, 8'h00, 32'h0,         32'hFFFF_FFFF, 32'h0000_03FF, 10'h2AD);
        add("status_ones", 1'b0, 8'h0C, 32'h0,         32'h3FF,       32'h0000_03FF, 10'h3FF);
        add("wr_dir_back", 1'b1, 8'h00, 32'h0000_02A5, 32'h0,         32'h0,         10'h3FF);
        add("wr_ch3_off",  1'b1, 8'h4C, 32'h0,         32'hFFFF_FFFF, PWM_ON ? 32'h0001_0080 : 32'h0001_0000, 10'h3FF);
        add("led_restore", 1'b0, 8'h00, 32'h0,         32'hFFFF_FFFF, 32'h0000_02A5, 10'h2AD);
        add("led_final",   1'b0, 8'h0C, 32'h0,         32'h3FF,       32'h0000_02A5, 10'h2A5);

        repeat (2) @(negedge clk);
        chk("reset_ledr", 32'(ledr), 32'h0);
        chk("reset_ack_idle", 32'(ack_w === 1'b1), 32'h0);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            @(posedge clk);
            #1;
            write_i = vecs[k].wr;
            read_i  = !vecs[k].wr;
            addr_i  = BASE | {24'h0, vecs[k].ofs};
            data_i  = vecs[k].wd;
            @(negedge clk);
            chk({vecs[k].nm, "_ack"}, 32'(ack_w), 32'h1);
            if (vecs[k].dmask != 32'h0) begin
                chk({vecs[k].nm, "_data"}, data_w & vecs[k].dmask, vecs[k].dexp & vecs[k].dmask);
            end
            chk({vecs[k].nm, "_led"}, 32'(ledr), 32'(vecs[k].lexp));
        end

        // Window decode: one page above the base must not answer.
        @(posedge clk);
        #1;
        write_i = 1'b0;
        read_i  = 1'b1;
        addr_i  = BASE + 32'h100;
        @(negedge clk);
        chk("oow_ack", 32'(ack_w === 1'b1), 32'h0);
        chk("oow_data", 32'(data_w === 32'h0000_02A5), 32'h0);
        read_i = 1'b0;
        addr_i = BASE;
        #1;
        chk("nostrobe_ack", 32'(ack_w === 1'b1), 32'h0);

        // PWM duty boundaries on channel 0, one tick per clk.
        do_write(8'h04, 32'h0);
        do_write(8'h40, 32'h0001_0040);
        repeat (2) @(negedge clk);
        count_on(n);
        chk("pwm_duty64", 32'(n), PWM_ON ? 32'd64 : 32'd256);
        do_write(8'h40, 32'h0001_0000);
        repeat (2) @(negedge clk);
        count_on(n);
        chk("pwm_duty0", 32'(n), PWM_ON ? 32'd0 : 32'd256);
        do_write(8'h40, 32'h0001_00FF);
        repeat (2) @(negedge clk);
        count_on(n);
        chk("pwm_duty255", 32'(n), PWM_ON ? 32'd255 : 32'd256);

        // Blink on channel 1 from a freshly cleared timebase.
        do_write(8'h04, 32'h3);
        do_write(8'h44, 32'h0002_0000);
        do_write(8'h08, 32'h1);
        blink_mon("blink");

        // Rewrite BLINK mid-period while phase is high.
        repeat (H) @(negedge clk);
        chk("pre_clr_phase", 32'(data_w[31]), 32'h1);
        do_write(8'h08, 32'h1);
        blink_mon("mid_clr");

        // Asynchronous reset between clock edges.
        chk("pre_rst_led", 32'(ledr & 10'h3FC), 32'h2A4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ledr", 32'(ledr), 32'h0);
        chk("async_rst_status", data_w, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        addr_i = BASE | 32'h44;
        #1;
        chk("post_rst_ch1", data_w, 32'h0);
        addr_i = BASE | 32'h04;
        #1;
        chk("post_rst_presc", data_w, 32'h0);
        @(negedge clk);
        chk("post_rst_ledr", 32'(ledr), 32'h0);
        read_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
